// File: rtl/fe_arbiter.sv
// Round-robin arbiter that shares the single host Avalon front-end channel
// among NDEV device request ports, signalling pending data via interrupt.
module fe_arbiter #(
  parameter int unsigned NDEV = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NDEV-1:0]      dev_rq,
  output logic [NDEV-1:0]      dev_s_read,
  input  logic [32*NDEV-1:0]   dev_readdata,
  input  logic [1:0]           h_address,
  input  logic                 h_read,
  output logic [31:0]          h_readdata,
  output logic                 h_irq
);

  localparam int unsigned IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int unsigned DW   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              h_irq_q, h_irq_d;

  logic [IDXW-1:0]   pick_c;
  logic              pick_vld_c;
  logic [31:0]       srch_c;
  logic              in_grant_c;
  logic              data_rd_c;
  logic [DW-1:0]     sel_data_c;

  function automatic logic [IDXW-1:0] nxt_idx(input logic [IDXW-1:0] i);
    if (32'(i) == NDEV - 1) return '0;
    return i + IDXW'(1);
  endfunction

  assign in_grant_c = (state_q == GRANT);
  // A data read is only honoured while granted and never during reset
  assign data_rd_c  = in_grant_c && h_read && (h_address == 2'd1) && !reset;
  assign sel_data_c = dev_readdata[{grant_q, 5'b0} +: DW];

  // First set request searching upward from the rr pointer, with wrap
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    srch_c     = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      srch_c = 32'(rr_q) + k;
      if (srch_c >= NDEV) srch_c = srch_c - NDEV;
      if (!pick_vld_c && dev_rq[IDXW'(srch_c)]) begin
        pick_c     = IDXW'(srch_c);
        pick_vld_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      h_irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      h_irq_q <= h_irq_d;
    end
  end

  // Next-state: a data read wins over a same-cycle withdrawal
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          grant_d = pick_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (data_rd_c) begin
          rr_d    = nxt_idx(grant_q);
          cnt_d   = cnt_q + CNTW'(1);
          state_d = HOLD;
        end else if (!dev_rq[grant_q]) begin
          rr_d    = nxt_idx(grant_q);
          state_d = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    h_irq_d = (state_d == GRANT);
  end

  // Host read mux and device strobe
  always_comb begin
    dev_s_read = '0;
    h_readdata = '0;
    if (data_rd_c) dev_s_read[grant_q] = 1'b1;
    if (h_read && !reset) begin
      case (h_address)
        2'd0:    h_readdata = {in_grant_c, 28'b0, in_grant_c ? 3'(grant_q) : 3'b0};
        2'd1:    h_readdata = in_grant_c ? sel_data_c : '0;
        2'd2:    h_readdata = 32'(cnt_q);
        default: h_readdata = {24'b0, 8'(dev_rq)};
      endcase
    end
  end

  assign h_irq = h_irq_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(dev_s_read));
  a_strobe_in_grant: assert property (@(posedge clk) disable iff (reset)
    (|dev_s_read) |-> (state_q == GRANT));

endmodule

// File: tb/tb_fe_arbiter.sv
// Directed bench for fe_arbiter: reset, round-robin order, withdrawal,
// spurious reads, reset mid-grant and read/withdraw collision.
module tb_fe_arbiter;

  localparam int unsigned NDEV = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NDEV-1:0]      dev_rq;
  logic [NDEV-1:0]      dev_s_read;
  logic [32*NDEV-1:0]   dev_readdata;
  logic [1:0]           h_address;
  logic                 h_read;
  logic [31:0]          h_readdata;
  logic                 h_irq;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] words [NDEV] = '{32'h000000A5, 32'h11111111, 32'h22222222, 32'h33333333};
  int          order [4]    = '{0, 1, 3, 0};

  fe_arbiter #(.NDEV(NDEV), .CNTW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .dev_rq       (dev_rq),
    .dev_s_read   (dev_s_read),
    .dev_readdata (dev_readdata),
    .h_address    (h_address),
    .h_read       (h_read),
    .h_readdata   (h_readdata),
    .h_irq        (h_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One zero-wait host read: sample mid-low-phase, retire on the next edge
  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [NDEV-1:0] s);
    h_address = a;
    h_read    = 1'b1;
    #1;
    d = h_readdata;
    s = dev_s_read;
    tick();
    h_read = 1'b0;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 8; i++) begin
      if (h_irq) break;
      tick();
    end
    chk("irq_wait", 32'(h_irq), 32'd1);
  endtask

  logic [31:0]     d;
  logic [NDEV-1:0] s;

  initial begin
    reset     = 1'b1;
    dev_rq    = '0;
    h_address = 2'd0;
    h_read    = 1'b0;
    for (int i = 0; i < NDEV; i++) dev_readdata[32*i +: 32] = words[i];
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_irq", 32'(h_irq), 32'd0);
    chk("rst_sread", 32'(dev_s_read), 32'd0);
    chk("rst_rdata_idle", h_readdata, 32'd0);
    rd(2'd2, d, s);
    chk("rst_cnt", d, 32'd0);

    // Single request
    dev_rq = 4'b0001;
    #1;
    chk("single_irq_pre", 32'(h_irq), 32'd0);
    tick();
    chk("single_irq", 32'(h_irq), 32'd1);
    rd(2'd0, d, s);
    chk("single_status", d, 32'h80000000);
    rd(2'd1, d, s);
    chk("single_data", d, 32'h000000A5);
    chk("single_strobe", 32'(s), 32'h1);
    dev_rq = 4'b0000;
    #1;
    chk("single_irq_drop", 32'(h_irq), 32'd0);
    chk("single_strobe_drop", 32'(dev_s_read), 32'd0);
    rd(2'd2, d, s);
    chk("single_cnt", d, 32'd1);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dev_rq = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      wait_irq();
      if (n == 0) begin
        rd(2'd3, d, s);
        chk("rr_rq_snap", d, 32'h0000000B);
      end
      rd(2'd0, d, s);
      chk($sformatf("rr_status%0d", n), d, 32'h80000000 | 32'(order[n]));
      rd(2'd1, d, s);
      chk($sformatf("rr_data%0d", n), d, words[order[n]]);
      chk($sformatf("rr_strobe%0d", n), 32'(s), 32'd1 << order[n]);
    end
    dev_rq = 4'b0000;
    rd(2'd2, d, s);
    chk("rr_cnt", d, 32'd4);

    // Withdrawal: rr is 1, only dev 2 asks
    dev_rq = 4'b0100;
    tick();
    rd(2'd0, d, s);
    chk("wd_status", d, 32'h80000002);
    dev_rq = 4'b0000;
    #1;
    chk("wd_strobe", 32'(dev_s_read), 32'd0);
    tick();
    chk("wd_irq", 32'(h_irq), 32'd0);
    rd(2'd2, d, s);
    chk("wd_cnt", d, 32'd4);
    dev_rq = 4'b1111;
    tick();
    rd(2'd0, d, s);
    chk("wd_rr3", d, 32'h80000003);
    dev_rq = 4'b0000;
    tick();
    tick();

    // Spurious reads in IDLE
    rd(2'd1, d, s);
    chk("spur_data", d, 32'd0);
    chk("spur_strobe", 32'(s), 32'd0);
    rd(2'd0, d, s);
    chk("spur_status", d, 32'd0);

    // Reset mid-GRANT
    dev_rq = 4'b0100;
    tick();
    chk("rg_irq", 32'(h_irq), 32'd1);
    reset     = 1'b1;
    h_address = 2'd1;
    h_read    = 1'b1;
    #1;
    chk("rg_strobe_in_rst", 32'(dev_s_read), 32'd0);
    tick();
    h_read = 1'b0;
    chk("rg_irq_rst", 32'(h_irq), 32'd0);
    reset = 1'b0;
    rd(2'd2, d, s);
    chk("rg_cnt", d, 32'd0);
    chk("rg_irq_regrant", 32'(h_irq), 32'd1);
    rd(2'd0, d, s);
    chk("rg_status", d, 32'h80000002);

    // No read strobe: data port stays quiet
    h_address = 2'd1;
    h_read    = 1'b0;
    #1;
    chk("noread_rdata", h_readdata, 32'd0);
    chk("noread_strobe", 32'(dev_s_read), 32'd0);

    // Same-cycle data read and withdrawal
    dev_rq = 4'b0000;
    rd(2'd1, d, s);
    chk("coll_data", d, 32'h22222222);
    chk("coll_strobe", 32'(s), 32'h4);
    chk("coll_irq", 32'(h_irq), 32'd0);
    rd(2'd2, d, s);
    chk("coll_cnt", d, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
